// File: rtl/eight_bit_compute_unit_if.sv
// Operand and result bundle for the 8-bit adder/multiplier stage.
// The master drives operands; the slave (the compute unit) returns registered results.
interface eight_bit_compute_unit_if;
    logic [7:0] a_add;
    logic [7:0] b_add;
    logic       cin;
    logic [7:0] a_mul;
    logic [7:0] b_mul;
    logic [7:0] sum;
    logic       cout;
    logic [7:0] mul;
    logic       mul_ovf;

    modport master (
        output a_add, b_add, cin, a_mul, b_mul,
        input  sum, cout, mul, mul_ovf
    );

    modport slave (
        input  a_add, b_add, cin, a_mul, b_mul,
        output sum, cout, mul, mul_ovf
    );
endinterface

// File: rtl/eight_bit_compute_unit.sv
// Arithmetic stage: ripple-carry 8-bit adder and 8x8 shift-and-add multiplier,
// each built from 1-bit full adders, with results captured one cycle later.
module eight_bit_compute_unit (
    input  logic                      CLK,
    input  logic                      RST_N,
    eight_bit_compute_unit_if.slave   bus
);

    logic [7:0]  add_sum;
    logic        add_cout;
    logic [15:0] product;

    // Adder: carry ripples LSB to MSB through eight full adders.
    always_comb begin
        logic carry;
        add_sum = '0;
        carry   = bus.cin;
        for (int i = 0; i < 8; i++) begin
            add_sum[i] = bus.a_add[i] ^ bus.b_add[i] ^ carry;
            carry      = (bus.a_add[i] & bus.b_add[i]) |
                         (bus.a_add[i] & carry) |
                         (bus.b_add[i] & carry);
        end
        add_cout = carry;
    end

    // Multiplier: accumulate each shifted partial product with a 16-bit
    // full-adder row. The final row cannot carry out since 255*255 < 2^16.
    always_comb begin
        logic [15:0] acc;
        logic [15:0] pp;
        logic [15:0] row;
        logic        carry;
        acc   = '0;
        pp    = '0;
        row   = '0;
        carry = 1'b0;
        for (int j = 0; j < 8; j++) begin
            pp    = {8'h00, bus.a_mul & {8{bus.b_mul[j]}}} << j;
            carry = 1'b0;
            for (int i = 0; i < 16; i++) begin
                row[i] = acc[i] ^ pp[i] ^ carry;
                carry  = (acc[i] & pp[i]) | (acc[i] & carry) | (pp[i] & carry);
            end
            acc = row;
        end
        product = acc;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            bus.sum     <= '0;
            bus.cout    <= 1'b0;
            bus.mul     <= '0;
            bus.mul_ovf <= 1'b0;
        end else begin
            bus.sum     <= add_sum;
            bus.cout    <= add_cout;
            bus.mul     <= product[7:0];
            bus.mul_ovf <= |product[15:8];
        end
    end

endmodule

// File: tb/tb_eight_bit_compute_unit.sv
// Self-checking bench for eight_bit_compute_unit: expected results are queued
// when operands are driven and compared after the capturing edge.
module tb_eight_bit_compute_unit;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic [7:0] mul;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    exp_t  sb_q[$];
    string nm_q[$];

    eight_bit_compute_unit_if bus ();

    eight_bit_compute_unit dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive one operand set, queue its expected result, capture on the next edge
    // and compare the popped expectation against the registered outputs.
    task automatic step(input logic rst, input logic [7:0] aa, input logic [7:0] ba,
                        input logic ci, input logic [7:0] am, input logic [7:0] bm,
                        input logic [7:0] es, input logic ec, input logic [7:0] em,
                        input logic eo, input string nm);
        exp_t  e;
        string n;
        rst_n     = rst;
        bus.a_add = aa;
        bus.b_add = ba;
        bus.cin   = ci;
        bus.a_mul = am;
        bus.b_mul = bm;
        e.sum  = es;
        e.cout = ec;
        e.mul  = em;
        e.ovf  = eo;
        sb_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n = nm_q.pop_front();
        n_checks += 4;
        if (bus.sum !== e.sum) begin
            n_fails++;
            $display("FAIL %s sum: got %0d expected %0d", n, bus.sum, e.sum);
        end
        if (bus.cout !== e.cout) begin
            n_fails++;
            $display("FAIL %s cout: got %b expected %b", n, bus.cout, e.cout);
        end
        if (bus.mul !== e.mul) begin
            n_fails++;
            $display("FAIL %s mul: got %0d expected %0d", n, bus.mul, e.mul);
        end
        if (bus.mul_ovf !== e.ovf) begin
            n_fails++;
            $display("FAIL %s mul_ovf: got %b expected %b", n, bus.mul_ovf, e.ovf);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 8'd255, 8'd1, 1'b0, 8'd200, 8'd3, 8'd0, 1'b0, 8'd0, 1'b0, "reset_edge1");
        step(1'b0, 8'd255, 8'd1, 1'b0, 8'd200, 8'd3, 8'd0, 1'b0, 8'd0, 1'b0, "reset_edge2");
    endtask

    task automatic test_mul_truncation();
        step(1'b1, 8'd0, 8'd0, 1'b0, 8'd15, 8'd16, 8'd0, 1'b0, 8'd240, 1'b0, "mul_15x16");
        step(1'b1, 8'd0, 8'd0, 1'b0, 8'd16, 8'd16, 8'd0, 1'b0, 8'd0,   1'b1, "mul_16x16");
        step(1'b1, 8'd0, 8'd0, 1'b0, 8'd17, 8'd16, 8'd0, 1'b0, 8'd16,  1'b1, "mul_17x16");
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 16; a++) begin
            logic [7:0] av;
            av = 8'(a);
            step(1'b1, av, 8'd5, 1'b0, av, 8'd5, 8'(a + 5), 1'b0, 8'(a * 5), 1'b0, "sweep");
        end
    endtask

    task automatic test_mixed();
        step(1'b1, 8'd9, 8'd13, 1'b0, 8'd9, 8'd13, 8'd22, 1'b0, 8'd117, 1'b0, "mixed_9_13");
        // adder inputs swing while multiplier inputs stay fixed, and vice versa
        step(1'b1, 8'd200, 8'd100, 1'b1, 8'd9, 8'd13, 8'd45, 1'b1, 8'd117, 1'b0, "indep_add_changes");
        step(1'b1, 8'd200, 8'd100, 1'b1, 8'd128, 8'd2, 8'd45, 1'b1, 8'd0, 1'b1, "indep_mul_changes");
    endtask

    task automatic test_carry_bounds();
        step(1'b1, 8'd255, 8'd1,   1'b0, 8'd0, 8'd0, 8'd0,   1'b1, 8'd0, 1'b0, "add_255_1");
        step(1'b1, 8'd255, 8'd255, 1'b1, 8'd0, 8'd0, 8'd255, 1'b1, 8'd0, 1'b0, "add_255_255_c1");
        step(1'b1, 8'd0,   8'd0,   1'b1, 8'd0, 8'd0, 8'd1,   1'b0, 8'd0, 1'b0, "add_0_0_c1");
    endtask

    task automatic test_mul_extremes();
        step(1'b1, 8'd0, 8'd0, 1'b0, 8'd255, 8'd255, 8'd0, 1'b0, 8'd1,   1'b1, "mul_255x255");
        step(1'b1, 8'd0, 8'd0, 1'b0, 8'd0,   8'd255, 8'd0, 1'b0, 8'd0,   1'b0, "mul_0x255");
        step(1'b1, 8'd0, 8'd0, 1'b0, 8'd1,   8'd255, 8'd0, 1'b0, 8'd255, 1'b0, "mul_1x255");
    endtask

    task automatic test_back_to_back_reset();
        step(1'b1, 8'd255, 8'd1, 1'b0, 8'd255, 8'd255, 8'd0, 1'b1, 8'd1,   1'b1, "rp_255x255");
        step(1'b0, 8'd255, 8'd1, 1'b0, 8'd0,   8'd255, 8'd0, 1'b0, 8'd0,   1'b0, "rp_reset_pulse");
        step(1'b1, 8'd255, 8'd1, 1'b0, 8'd1,   8'd255, 8'd0, 1'b1, 8'd255, 1'b0, "rp_1x255");
    endtask

    // Operand changes after an edge must not reach the outputs before the next edge.
    task automatic test_hold();
        step(1'b1, 8'd10, 8'd20, 1'b0, 8'd7, 8'd6, 8'd30, 1'b0, 8'd42, 1'b0, "hold_load");
        bus.a_add = 8'd250;
        bus.b_add = 8'd250;
        bus.a_mul = 8'd99;
        bus.b_mul = 8'd99;
        #5;
        n_checks += 2;
        if (bus.sum !== 8'd30) begin
            n_fails++;
            $display("FAIL hold_sum: got %0d expected %0d", bus.sum, 8'd30);
        end
        if (bus.mul !== 8'd42) begin
            n_fails++;
            $display("FAIL hold_mul: got %0d expected %0d", bus.mul, 8'd42);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        bus.a_add = '0;
        bus.b_add = '0;
        bus.cin   = 1'b0;
        bus.a_mul = '0;
        bus.b_mul = '0;
        test_reset();
        test_mul_truncation();
        test_sweep();
        test_mixed();
        test_carry_bounds();
        test_mul_extremes();
        test_back_to_back_reset();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/eight_bit_compute_unit.md
# eight_bit_compute_unit

The block pairs an 8-bit ripple-carry adder and an 8x8 multiplier with a truncated 8-bit product. It is the arithmetic stage of the computation datapath. Both operators evaluate combinationally from their own independent operand inputs. Each result is captured in an output register on the rising clock edge.

## Interface
Parameters:
- none. Widths are fixed at 8 bits.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  reset, synchronous and active-low; sampled on the rising edge of CLK.
- a_add  input  8  adder operand A, unsigned.
- b_add  input  8  adder operand B, unsigned.
- cin  input  1  adder carry-in.
- a_mul  input  8  multiplier operand A, unsigned.
- b_mul  input  8  multiplier operand B, unsigned.
- sum  output  8  registered adder result, bits [7:0] of a_add + b_add + cin.
- cout  output  1  registered adder carry-out, bit 8 of a_add + b_add + cin.
- mul  output  8  registered product, bits [7:0] of a_mul * b_mul.
- mul_ovf  output  1  registered flag; 1 when bits [15:8] of the full product are nonzero.

## Operation
- The adder is a ripple chain of eight 1-bit full adders.
  - Per bit: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = cin; cout = c_8.
- The multiplier is an unsigned shift-and-add array built from 1-bit full adders.
  - Partial products: pp_j = (a_mul & {8{b_mul[j]}}) << j.
  - All pp_j are summed to a 16-bit product P.
  - mul = P[7:0]; mul_ovf = |P[15:8].
  - The high byte is not otherwise exported.
- The two operators are fully independent. Changing the adder inputs never affects the multiplier outputs, and the reverse also holds.
- Arithmetic is unsigned only. Adder wrap-around: a 9-bit result of 256 or more wraps sum modulo 256, with cout = 1.
- No enables and no handshake. The output registers load every cycle that RST_N = 1.

## Timing
- Latency is 1 cycle. Operands present before rising edge N appear on the outputs after edge N.
- Throughput is one new operand set per operator per cycle.
- Both combinational paths (8-bit carry ripple; multiplier array) must settle within one CLK period. The target period is 20 ns (50 MHz).
- Reset: if RST_N = 0 at a rising edge, then after that edge sum = 0, cout = 0, mul = 0 and mul_ovf = 0.
  - Outputs stay at 0 for every edge at which RST_N is 0, regardless of the operands.
- Deassertion: the first edge with RST_N = 1 loads results from the operands present at that edge.
- Reset mid-operation: in-flight results are discarded. There is no pipeline to flush beyond the single output register.
- Operand changes between edges have no effect on the outputs until the next rising edge.
- Outputs are X-free after the first reset edge.

## Test plan
- Reset: hold RST_N = 0 for 2 edges with a_mul = 200, b_mul = 3, a_add = 255, b_add = 1 -> sum = 0, cout = 0, mul = 0, mul_ovf = 0.
- Multiplier truncation, one result per cycle after 1 cycle of latency:
  - 15 * 16 -> mul = 240, ovf = 0.
  - 16 * 16 -> mul = 0, ovf = 1.
  - 17 * 16 -> mul = 16, ovf = 1.
- Sweep: b_mul = b_add = 5, cin = 0, with a_mul = a_add = 0..15 applied one per cycle.
  - Each following cycle: mul = 5a mod 256, sum = a + 5, cout = 0.
  - At a = 15: mul = 75, sum = 20.
- Mixed and independence:
  - a_mul = 9, b_mul = 13 -> mul = 117, ovf = 0.
  - In the same cycle, a_add = 9, b_add = 13 -> sum = 22, cout = 0.
- Adder carry boundaries:
  - 255 + 1, cin = 0 -> sum = 0, cout = 1.
  - 255 + 255, cin = 1 -> sum = 255, cout = 1.
  - 0 + 0, cin = 1 -> sum = 1, cout = 0.
- Multiplier extremes:
  - 255 * 255 -> mul = 1, ovf = 1.
  - 0 * 255 -> mul = 0, ovf = 0.
  - 1 * 255 -> mul = 255, ovf = 0.
  - Repeat with RST_N pulsed low for one edge mid-sequence -> zeros on that cycle only.
